// File: rtl/niosii_system_sysid_checker_pkg.sv
// niosII_system_sysid_pkg: checker state encoding, sysid word addresses and default expected values.
package niosII_system_sysid_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_DONE
    } sysid_state_e;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1487635183;
endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// niosii_system_sysid_checker_if: Avalon-MM read-only link between the checker (master) and the sysid control slave.
interface niosii_system_sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    modport master (output address, read, input waitrequest, readdata, readdatavalid);
    modport slave (input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/niosii_system_sysid_checker_watchdog.sv
// niosII_system_sysid_watchdog: clearable, enable-gated per-read cycle counter with terminal-count flag.
module niosII_system_sysid_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    logic [W-1:0] count;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    // Fires on the cycle whose increment makes the count reach LIMIT.
    assign tc = en & (count == LAST);
endmodule

// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker: reads sysid words 0/1 over Avalon-MM and flags ID/timestamp match.
// Optional read watchdog built only when SYSID_CHECK_TIMEOUT_EN is defined.
module niosii_system_sysid_checker
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    niosii_system_sysid_checker_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    sysid_state_e state, state_n;
    logic restart, accept, id_cap, ts_cap, tc, to_hit, id_hit, ts_hit;
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = state == ST_DONE;
    assign bus.read    = (state == ST_ID_REQ) || (state == ST_TS_REQ);
    assign bus.address = (state == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign restart     = ~busy & start;
    assign accept      = bus.read & ~bus.waitrequest;
    assign id_cap      = (state == ST_ID_WAIT) & bus.readdatavalid;
    assign ts_cap      = (state == ST_TS_WAIT) & bus.readdatavalid;
    assign ts_hit      = ts_cap & (bus.readdata == EXPECTED_TS);
    // A response arriving on the terminal cycle still wins over the timeout.
    assign to_hit      = tc & ~id_cap & ~ts_cap;
`ifdef SYSID_CHECK_TIMEOUT_EN
    niosII_system_sysid_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (restart | id_cap),
        .en     (busy),
        .tc     (tc)
    );
`else
    assign tc = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: state_n = start ? ST_ID_REQ : state;
            ST_ID_REQ:        state_n = to_hit ? ST_DONE : accept ? ST_ID_WAIT : state;
            ST_ID_WAIT:       state_n = id_cap ? ST_TS_REQ : to_hit ? ST_DONE : state;
            ST_TS_REQ:        state_n = to_hit ? ST_DONE : accept ? ST_TS_WAIT : state;
            ST_TS_WAIT:       state_n = (ts_cap | to_hit) ? ST_DONE : state;
            default:          state_n = ST_IDLE;
        endcase
    end
    // id_hit holds the ID verdict internally so the visible flags only move on DONE entry.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
            id_hit   <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            match    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (restart) begin
                id_value <= '0;
                ts_value <= '0;
                id_hit   <= 1'b0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                match    <= 1'b0;
                timeout  <= 1'b0;
            end
            if (id_cap) begin
                id_value <= bus.readdata;
                id_hit   <= bus.readdata == EXPECTED_ID;
            end
            if (ts_cap) ts_value <= bus.readdata;
            if (ts_cap | to_hit) begin
                id_ok   <= id_hit;
                ts_ok   <= ts_hit;
                match   <= id_hit & ts_hit;
                timeout <= to_hit;
            end
        end
endmodule
